// File: rtl/ieee_fixed_to_float.sv
// Converts a 5.5 fixed-point operand into an IEEE-754 single-precision word, one cycle latency.
// Define IEEE_SIGNED_EN to treat in1[4] as a sign bit over a 4-bit integer magnitude.
module ieee_fixed_to_float (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  in1,
    input  logic [4:0]  in2,
    input  logic        in_valid,
    output logic [31:0] out,
    output logic [22:0] mantissa,
    output logic [7:0]  exponent,
    output logic [4:0]  temp,
    output logic [4:0]  temp2,
    output logic        out_valid
);

    localparam int unsigned XWidth   = 10;
    localparam int unsigned FracBits = 5;
    localparam int unsigned Bias     = 127;
    localparam int unsigned ManWidth = 23;

    // Exponent of the leading one at bit 0, i.e. the smallest non-zero value 1/32.
    localparam logic [7:0] ExpBase = 8'(Bias - FracBits);

    logic [XWidth-1:0]   mag_x;
    logic                sign_in;
    logic                is_zero;
    logic [3:0]          lead_pos;
    logic [4:0]          shift_amt;
    logic [7:0]          exp_calc;
    logic [ManWidth-1:0] mant_calc;

    logic                sign_d,      sign_q;
    logic [7:0]          exponent_d,  exponent_q;
    logic [ManWidth-1:0] mantissa_d,  mantissa_q;
    logic [4:0]          temp_d,      temp_q;
    logic [4:0]          temp2_d,     temp2_q;
    logic                out_valid_d, out_valid_q;

    always_comb begin
`ifdef IEEE_SIGNED_EN
        mag_x   = {1'b0, in1[3:0], in2};
        sign_in = in1[4];
`else
        mag_x   = {in1, in2};
        sign_in = 1'b0;
`endif
        is_zero = (mag_x == '0);
    end

    // Highest set bit wins because later iterations override earlier ones.
    always_comb begin
        lead_pos = 4'd0;
        for (int i = 0; i < XWidth; i++) begin
            if (mag_x[i]) begin
                lead_pos = 4'(i);
            end
        end
    end

    // Shifting the implicit one to bit 23 drops it off the top of the 23-bit field.
    always_comb begin
        shift_amt = 5'(ManWidth) - {1'b0, lead_pos};
        mant_calc = {13'b0, mag_x} << shift_amt;
        exp_calc  = ExpBase + {4'b0, lead_pos};
    end

    always_comb begin
        sign_d      = sign_q;
        exponent_d  = exponent_q;
        mantissa_d  = mantissa_q;
        temp_d      = temp_q;
        temp2_d     = temp2_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            temp_d  = in1;
            temp2_d = in2;
            if (is_zero) begin
                sign_d     = 1'b0;
                exponent_d = 8'd0;
                mantissa_d = '0;
            end else begin
                sign_d     = sign_in;
                exponent_d = exp_calc;
                mantissa_d = mant_calc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            exponent_q  <= 8'd0;
            mantissa_q  <= '0;
            temp_q      <= 5'd0;
            temp2_q     <= 5'd0;
            out_valid_q <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            exponent_q  <= exponent_d;
            mantissa_q  <= mantissa_d;
            temp_q      <= temp_d;
            temp2_q     <= temp2_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = {sign_q, exponent_q, mantissa_q};
    assign mantissa  = mantissa_q;
    assign exponent  = exponent_q;
    assign temp      = temp_q;
    assign temp2     = temp2_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ieee_fixed_to_float.sv
// Scoreboard bench for ieee_fixed_to_float; honours IEEE_SIGNED_EN like the design.
module tb_ieee_fixed_to_float;

    logic        clk;
    logic        rst_n;
    logic [4:0]  in1;
    logic [4:0]  in2;
    logic        in_valid;
    logic [31:0] out;
    logic [22:0] mantissa;
    logic [7:0]  exponent;
    logic [4:0]  temp;
    logic [4:0]  temp2;
    logic        out_valid;

    typedef struct packed {
        logic [31:0] o;
        logic [7:0]  e;
        logic [22:0] m;
        logic [4:0]  t1;
        logic [4:0]  t2;
    } res_t;

    res_t sbq[$];
    res_t last_res;
    res_t got;
    res_t want;
    int   tests;
    int   fails;

    ieee_fixed_to_float dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .out       (out),
        .mantissa  (mantissa),
        .exponent  (exponent),
        .temp      (temp),
        .temp2     (temp2),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: find the leading one by search, strip it, left-align the rest.
    function automatic res_t model(input logic [4:0] a, input logic [4:0] b);
        res_t r;
        int   x;
        int   p;
        logic s;
`ifdef IEEE_SIGNED_EN
        x = int'(a[3:0]) * 32 + int'(b);
        s = a[4];
`else
        x = int'(a) * 32 + int'(b);
        s = 1'b0;
`endif
        r.t1 = a;
        r.t2 = b;
        if (x == 0) begin
            r.o = 32'h0;
            r.e = 8'h0;
            r.m = 23'h0;
        end else begin
            p = 9;
            while (((x >> p) & 1) == 0) p--;
            r.e = 8'(122 + p);
            r.m = 23'((x - (1 << p)) << (23 - p));
            r.o = {s, r.e, r.m};
        end
        return r;
    endfunction

    function automatic res_t from_const(input logic [31:0] o, input logic [4:0] a,
                                        input logic [4:0] b);
        res_t r;
        r.o  = o;
        r.e  = o[30:23];
        r.m  = o[22:0];
        r.t1 = a;
        r.t2 = b;
        return r;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = 5'd0;
        in2      = 5'd0;
        #2;
        got = {out, exponent, mantissa, temp, temp2};
        tests++;
        if (got !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_initial got=%h ov=%b want=0 ov=0", got, out_valid);
        end
        // Operands offered while reset is held are discarded.
        in1      = 5'd7;
        in2      = 5'd3;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = {out, exponent, mantissa, temp, temp2};
        tests++;
        if (got !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_held got=%h ov=%b want=0 ov=0", got, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out !== 32'h0) begin
            fails++;
            $display("FAIL reset_release got out=%h ov=%b want out=0 ov=0", out, out_valid);
        end
        last_res = '0;
    endtask

    task automatic test_vectors();
        res_t tbl[$];
        logic [4:0] a[$];
        logic [4:0] b[$];
        a = '{5'd0, 5'd4, 5'd6, 5'd0};
        b = '{5'd0, 5'd4, 5'd7, 5'd1};
        tbl.push_back(from_const(32'h00000000, 5'd0, 5'd0));
        tbl.push_back(from_const(32'h40840000, 5'd4, 5'd4));
        tbl.push_back(from_const(32'h40C70000, 5'd6, 5'd7));
        tbl.push_back(from_const(32'h3D000000, 5'd0, 5'd1));
`ifdef IEEE_SIGNED_EN
        a.push_back(5'b10100); b.push_back(5'd4);
        tbl.push_back(from_const(32'hC0840000, 5'b10100, 5'd4));
        a.push_back(5'b10000); b.push_back(5'd0);
        tbl.push_back(from_const(32'h00000000, 5'b10000, 5'd0));
        a.push_back(5'd31); b.push_back(5'd31);
        tbl.push_back(from_const(32'hC17F8000, 5'd31, 5'd31));
`else
        a.push_back(5'd31); b.push_back(5'd31);
        tbl.push_back(from_const(32'h41FFC000, 5'd31, 5'd31));
        a.push_back(5'd20); b.push_back(5'd4);
        tbl.push_back(from_const(32'h41A10000, 5'd20, 5'd4));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            in1      = a[i];
            in2      = b[i];
            in_valid = 1'b1;
            sbq.push_back(tbl[i]);
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL vec%0d_valid got=%b want=1", i, out_valid);
            end
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL vec%0d_queue got=empty want=entry", i);
            end else begin
                want = sbq.pop_front();
                got  = {out, exponent, mantissa, temp, temp2};
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL vec%0d got out=%h e=%h m=%h t=%h/%h want out=%h e=%h m=%h t=%h/%h",
                             i, got.o, got.e, got.m, got.t1, got.t2,
                             want.o, want.e, want.m, want.t1, want.t2);
                end
                last_res = want;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        in1 = 5'd9;
        in2 = 5'd17;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = {out, exponent, mantissa, temp, temp2};
            tests++;
            if (got !== last_res || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold%0d got=%h ov=%b want=%h ov=0", i, got, out_valid, last_res);
            end
            @(negedge clk);
            in1 = 5'($urandom_range(0, 31));
            in2 = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            in1      = 5'($urandom_range(0, 31));
            in2      = 5'($urandom_range(0, 31));
            in_valid = 1'b1;
            sbq.push_back(model(in1, in2));
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b%0d_valid got=%b want=1", i, out_valid);
            end
            if (sbq.size() != 0) begin
                want = sbq.pop_front();
                got  = {out, exponent, mantissa, temp, temp2};
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL b2b%0d in=%h/%h got out=%h e=%h m=%h want out=%h e=%h m=%h",
                             i, want.t1, want.t2, got.o, got.e, got.m, want.o, want.e, want.m);
                end
                last_res = want;
                n++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (n != 40) begin
            fails++;
            $display("FAIL b2b_count got=%0d want=40", n);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in1      = 5'd3;
        in2      = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        got = {out, exponent, mantissa, temp, temp2};
        tests++;
        if (got !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got=%h ov=%b want=0 ov=0", got, out_valid);
        end
        sbq.delete();
        @(negedge clk);
        in1 = 5'd11;
        @(posedge clk);
        #1;
        got = {out, exponent, mantissa, temp, temp2};
        tests++;
        if (got !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_discard got=%h ov=%b want=0 ov=0", got, out_valid);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out !== 32'h0) begin
            fails++;
            $display("FAIL post_reset_idle got out=%h ov=%b want out=0 ov=0", out, out_valid);
        end
        @(negedge clk);
        in1      = 5'd6;
        in2      = 5'd7;
        in_valid = 1'b1;
        sbq.push_back(from_const(32'h40C70000, 5'd6, 5'd7));
        @(posedge clk);
        #1;
        want = sbq.pop_front();
        got  = {out, exponent, mantissa, temp, temp2};
        tests++;
        if (got !== want || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_first got=%h ov=%b want=%h ov=1", got, out_valid, want);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
